// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the program-counter sequencer
package pc_seq_pkg;

  // Sequencer states: BOOT after reset, RUN while fetching, BUBBLE after a redirect, HALT when frozen
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2,
    ST_HALT   = 2'd3
  } pc_state_e;

  // Which source won the redirect priority mux this cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_JMP  = 2'd2,
    SRC_EXC  = 2'd3
  } redir_src_e;

  // Default instruction size and its alignment bit count
  localparam int DEF_INSTR_BYTES = 4;

  // log2 of a power-of-two instruction size; 1 byte gives 0 alignment bits
  function automatic int align_bits(input int bytes);
    int n;
    n = 0;
    while ((1 << n) < bytes) n++;
    return n;
  endfunction

  localparam int ALIGN_BITS = align_bits(DEF_INSTR_BYTES);

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - redirect priority mux, branch adder and alignment check
module pc_target_calc
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 10,
  parameter int              INSTR_BYTES = 4,
  parameter int              OFS_W       = 8,
  parameter logic [PC_W-1:0] VECTOR_PC   = PC_W'(12'h180)
) (
  input  logic              exc_valid,
  input  logic              jmp_valid,
  input  logic [PC_W-1:0]   jmp_target,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_base,
  input  logic [OFS_W-1:0]  br_ofs,
  output redir_src_e        src,
  output logic [PC_W-1:0]   target,
  output logic              misaligned
);

  localparam int              SHIFT      = align_bits(INSTR_BYTES);
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(INSTR_BYTES - 1);
  localparam logic [PC_W-1:0] INCR       = PC_W'(INSTR_BYTES);

  logic [31:0]     ofs_sx;
  logic [PC_W-1:0] ofs_bytes;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] raw_target;

  // Word offset is sign-extended then scaled to bytes; the sum wraps modulo 2^PC_W
  assign ofs_sx    = {{(32-OFS_W){br_ofs[OFS_W-1]}}, br_ofs};
  assign ofs_bytes = PC_W'(ofs_sx << SHIFT);
  assign br_target = br_base + INCR + ofs_bytes;

  // Priority mux: exception beats jump beats branch
  always_comb begin
    src        = SRC_NONE;
    raw_target = '0;
    if (exc_valid) begin
      src        = SRC_EXC;
      raw_target = VECTOR_PC;
    end else if (jmp_valid) begin
      src        = SRC_JMP;
      raw_target = jmp_target;
    end else if (br_taken) begin
      src        = SRC_BR;
      raw_target = br_target;
    end
  end

  // Low bits are cleared before loading; any set bit is reported as misaligned
  assign target     = raw_target & ~ALIGN_MASK;
  assign misaligned = |(raw_target & ALIGN_MASK);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter state machine and PC register for the fetch front end
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = 10,
  parameter int              INSTR_BYTES = 4,
  parameter int              OFS_W       = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [PC_W-1:0] VECTOR_PC   = PC_W'(12'h180)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_ready,
  input  logic              halt,
  input  logic              resume,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_base,
  input  logic [OFS_W-1:0]  br_ofs,
  input  logic              jmp_valid,
  input  logic [PC_W-1:0]   jmp_target,
  input  logic              exc_valid,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   npc_out,
  output logic              pc_valid,
  output logic              misalign
);

  localparam logic [PC_W-1:0] INCR = PC_W'(INSTR_BYTES);

  pc_state_e       state;
  logic [PC_W-1:0] pc;
  redir_src_e      redir_src;
  logic [PC_W-1:0] redir_target;
  logic            redir_misaligned;
  logic            redirect;

  pc_target_calc #(
    .PC_W        (PC_W),
    .INSTR_BYTES (INSTR_BYTES),
    .OFS_W       (OFS_W),
    .VECTOR_PC   (VECTOR_PC)
  ) u_target_calc (
    .exc_valid  (exc_valid),
    .jmp_valid  (jmp_valid),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_base    (br_base),
    .br_ofs     (br_ofs),
    .src        (redir_src),
    .target     (redir_target),
    .misaligned (redir_misaligned)
  );

  assign redirect = (redir_src != SRC_NONE);

  // State machine and PC register; a redirect wins over halt, resume and back-pressure in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (redirect) begin
        pc       <= redir_target;
        state    <= ST_BUBBLE;
        pc_valid <= 1'b0;
        misalign <= redir_misaligned;
      end else begin
        case (state)
          ST_BOOT: begin
            state    <= ST_RUN;
            pc_valid <= 1'b1;
          end
          ST_RUN: begin
            if (halt) begin
              state    <= ST_HALT;
              pc_valid <= 1'b0;
            end else if (fetch_ready) begin
              pc <= pc + INCR;
            end
          end
          ST_BUBBLE: begin
            state    <= ST_RUN;
            pc_valid <= 1'b1;
          end
          ST_HALT: begin
            if (resume && !halt) begin
              state    <= ST_RUN;
              pc_valid <= 1'b1;
            end
          end
          default: begin
            state    <= ST_BOOT;
            pc_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pc_out  = pc;
  assign npc_out = pc + INCR;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_ready;
  logic       halt;
  logic       resume;
  logic       br_taken;
  logic [9:0] br_base;
  logic [7:0] br_ofs;
  logic       jmp_valid;
  logic [9:0] jmp_target;
  logic       exc_valid;
  logic [9:0] pc_out;
  logic [9:0] npc_out;
  logic       pc_valid;
  logic       misalign;

  int checks = 0;
  int failures = 0;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_ready (fetch_ready),
    .halt        (halt),
    .resume      (resume),
    .br_taken    (br_taken),
    .br_base     (br_base),
    .br_ofs      (br_ofs),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .exc_valid   (exc_valid),
    .pc_out      (pc_out),
    .npc_out     (npc_out),
    .pc_valid    (pc_valid),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_ready = 1'b0; halt = 1'b0; resume = 1'b0;
    br_taken = 1'b0; br_base = '0; br_ofs = '0;
    jmp_valid = 1'b0; jmp_target = '0; exc_valid = 1'b0;
    tick(); tick();
    checks++; if (pc_out !== 10'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc_out); end
    checks++; if (npc_out !== 10'd4) begin failures++; $display("FAIL reset_npc got=%0d exp=4", npc_out); end
    checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    rst_n = 1'b1;
    fetch_ready = 1'b1;
    #1;
    checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", pc_valid); end
  endtask

  task automatic test_sequential();
    logic [9:0] exp_pc [4];
    exp_pc[0] = 10'd0; exp_pc[1] = 10'd4; exp_pc[2] = 10'd8; exp_pc[3] = 10'd12;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_out !== exp_pc[i] || pc_valid !== 1'b1) begin failures++; $display("FAIL seq_pc[%0d] got=%0d/%b exp=%0d/1", i, pc_out, pc_valid, exp_pc[i]); end
      checks++; if (npc_out !== exp_pc[i] + 10'd4) begin failures++; $display("FAIL seq_npc[%0d] got=%0d exp=%0d", i, npc_out, exp_pc[i] + 10'd4); end
    end
  endtask

  task automatic test_backpressure();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_out !== 10'd8 || pc_valid !== 1'b1) begin failures++; $display("FAIL stall_hold[%0d] got=%0d/%b exp=8/1", i, pc_out, pc_valid); end
    end
    fetch_ready = 1'b1;
    tick();
    checks++; if (pc_out !== 10'd12 || pc_valid !== 1'b1) begin failures++; $display("FAIL stall_release got=%0d/%b exp=12/1", pc_out, pc_valid); end
  endtask

  task automatic test_branch();
    br_taken = 1'b1; br_base = 10'd20; br_ofs = 8'hFD;
    tick();
    br_taken = 1'b0;
    checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL br_bubble got=%b exp=0", pc_valid); end
    tick();
    checks++; if (pc_out !== 10'd12 || pc_valid !== 1'b1) begin failures++; $display("FAIL br_back got=%0d/%b exp=12/1", pc_out, pc_valid); end
    br_taken = 1'b1; br_base = 10'd40; br_ofs = 8'd5;
    tick();
    br_taken = 1'b0;
    tick();
    checks++; if (pc_out !== 10'd64 || pc_valid !== 1'b1) begin failures++; $display("FAIL br_fwd got=%0d/%b exp=64/1", pc_out, pc_valid); end
  endtask

  task automatic test_priority();
    exc_valid = 1'b1; jmp_valid = 1'b1; jmp_target = 10'd100;
    br_taken = 1'b1; br_base = 10'd20; br_ofs = 8'd1;
    tick();
    exc_valid = 1'b0; jmp_valid = 1'b0; br_taken = 1'b0;
    checks++; if (pc_out !== 10'd384 || pc_valid !== 1'b0) begin failures++; $display("FAIL prio_bubble got=%0d/%b exp=384/0", pc_out, pc_valid); end
    tick();
    checks++; if (pc_out !== 10'd384 || pc_valid !== 1'b1) begin failures++; $display("FAIL prio_exc got=%0d/%b exp=384/1", pc_out, pc_valid); end
    jmp_valid = 1'b1; jmp_target = 10'd200; br_taken = 1'b1; br_base = 10'd0; br_ofs = 8'd0;
    tick();
    jmp_valid = 1'b0; br_taken = 1'b0;
    tick();
    checks++; if (pc_out !== 10'd200) begin failures++; $display("FAIL prio_jmp got=%0d exp=200", pc_out); end
  endtask

  task automatic test_misalign_wrap();
    jmp_valid = 1'b1; jmp_target = 10'd102;
    tick();
    jmp_valid = 1'b0;
    checks++; if (pc_out !== 10'd100 || misalign !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%0d/%b exp=100/1", pc_out, misalign); end
    tick();
    checks++; if (misalign !== 1'b0 || pc_valid !== 1'b1) begin failures++; $display("FAIL mis_clear got=%b/%b exp=0/1", misalign, pc_valid); end
    jmp_valid = 1'b1; jmp_target = 10'd1020;
    tick();
    jmp_valid = 1'b0;
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL aligned_jmp got=%b exp=0", misalign); end
    tick();
    checks++; if (pc_out !== 10'd1020 || npc_out !== 10'd0) begin failures++; $display("FAIL wrap_npc got=%0d/%0d exp=1020/0", pc_out, npc_out); end
    tick();
    checks++; if (pc_out !== 10'd0 || pc_valid !== 1'b1 || misalign !== 1'b0) begin failures++; $display("FAIL wrap_pc got=%0d/%b/%b exp=0/1/0", pc_out, pc_valid, misalign); end
  endtask

  task automatic test_halt_resume();
    jmp_valid = 1'b1; jmp_target = 10'd40;
    tick();
    jmp_valid = 1'b0;
    tick();
    halt = 1'b1;
    tick();
    checks++; if (pc_out !== 10'd40 || pc_valid !== 1'b0) begin failures++; $display("FAIL halt_enter got=%0d/%b exp=40/0", pc_out, pc_valid); end
    resume = 1'b1;
    tick();
    checks++; if (pc_out !== 10'd40 || pc_valid !== 1'b0) begin failures++; $display("FAIL halt_both got=%0d/%b exp=40/0", pc_out, pc_valid); end
    halt = 1'b0;
    tick();
    resume = 1'b0;
    checks++; if (pc_out !== 10'd40 || pc_valid !== 1'b1) begin failures++; $display("FAIL resume got=%0d/%b exp=40/1", pc_out, pc_valid); end
    tick();
    checks++; if (pc_out !== 10'd44) begin failures++; $display("FAIL resume_inc got=%0d exp=44", pc_out); end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    exc_valid = 1'b1;
    tick();
    exc_valid = 1'b0;
    tick();
    checks++; if (pc_out !== 10'd384 || pc_valid !== 1'b1) begin failures++; $display("FAIL exc_wake got=%0d/%b exp=384/1", pc_out, pc_valid); end
  endtask

  task automatic test_reset_mid();
    tick();
    jmp_valid = 1'b1; jmp_target = 10'd500;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc_out !== 10'd0 || pc_valid !== 1'b0) begin failures++; $display("FAIL async_reset got=%0d/%b exp=0/0", pc_out, pc_valid); end
    jmp_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (pc_out !== 10'd0 || pc_valid !== 1'b1) begin failures++; $display("FAIL reset_reboot got=%0d/%b exp=0/1", pc_out, pc_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch();
    test_priority();
    test_misalign_wrap();
    test_halt_resume();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit for the MIPS-32 fetch front end.
- Holds the architectural PC in a clocked register and produces PC+INSTR_BYTES.
- Selects the next PC from exception vector, jump, branch or sequential increment.
- Handles fetch back-pressure, halt/resume and a one-cycle flush bubble after every redirect.

Parameters:
- PC_W, 10, PC width in bits; all PC arithmetic is modulo 2^PC_W.
- INSTR_BYTES, 4, sequential increment; power of two, at least 1.
- OFS_W, 8, width of the signed branch word offset.
- RESET_PC, 0, PC value loaded at reset.
- VECTOR_PC, 'h180 truncated to PC_W, exception entry address.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- fetch_ready, input, 1, instruction fetch accepts pc_out this cycle.
- halt, input, 1, freeze the sequencer.
- resume, input, 1, leave HALT.
- br_taken, input, 1, taken-branch redirect request.
- br_base, input, PC_W, PC of the branch instruction.
- br_ofs, input, OFS_W, signed word offset.
- jmp_valid, input, 1, absolute jump request.
- jmp_target, input, PC_W, jump byte address.
- exc_valid, input, 1, exception redirect request.
- pc_out, output, PC_W, current fetch PC.
- npc_out, output, PC_W, pc_out+INSTR_BYTES, combinational from the PC register.
- pc_valid, output, 1, pc_out is a valid fetch request.
- misalign, output, 1, one-cycle pulse: redirect target was not INSTR_BYTES-aligned.

Behaviour:
- Reset state, while rst_n=0 (asynchronous):
  - pc_out=RESET_PC, npc_out=RESET_PC+INSTR_BYTES, pc_valid=0, misalign=0.
  - State is BOOT.
- States:
  - BOOT: pc_valid=0. Goes to RUN on the first clock edge after reset release.
  - RUN: pc_valid=1.
  - BUBBLE: pc_valid=0. Lasts exactly one cycle, then RUN.
  - HALT: pc_valid=0. PC is held.
- Redirect priority, evaluated each cycle in any state: exc_valid > jmp_valid > br_taken.
  - Exception target: VECTOR_PC.
  - Jump target: jmp_target.
  - Branch target: br_base + INSTR_BYTES + (sign_extend(br_ofs) * INSTR_BYTES), truncated to PC_W.
- A redirect takes effect on the next edge:
  - pc loads the target.
  - State becomes BUBBLE, so the new PC is valid 2 cycles after the request.
  - A redirect overrides halt and fetch_ready.
  - A redirect taken in HALT leaves HALT, i.e. exceptions wake the core.
- Alignment:
  - Target low log2(INSTR_BYTES) bits are forced to 0 before loading.
  - misalign pulses the cycle after load if any of those bits were nonzero.
- RUN, no redirect:
  - halt=1 -> HALT, PC held.
  - Otherwise fetch_ready=1 -> pc <= npc_out.
  - Otherwise hold pc; pc_valid stays 1 and pc_out stays stable (valid/ready hold rule).
- HALT, no redirect: resume=1 -> RUN with PC unchanged. halt and resume both 1 -> stay in HALT.
- Wrap-around: PC at 2^PC_W-INSTR_BYTES plus increment yields 0, with no flag.
- Reset assertion mid-operation returns immediately to BOOT/RESET_PC and discards any pending redirect.

Decomposition:
- Package pc_seq_pkg holds:
  - the state enum (BOOT, RUN, BUBBLE, HALT);
  - the redirect-source encoding;
  - ALIGN_BITS = log2(INSTR_BYTES).
- One sub-module, pc_target_calc (combinational):
  - priority mux;
  - branch adder;
  - alignment and misalign detection.
- pc_sequencer keeps the state machine and PC register.

Test Plan:
- Reset release, fetch_ready=1 for 4 cycles (defaults):
  - BOOT one cycle with pc_valid=0;
  - then pc_out 0, 4, 8, 12 with pc_valid=1;
  - npc_out always pc_out+4.
- Back-pressure at pc_out=8, fetch_ready=0 for 3 cycles -> pc_out stays 8 and pc_valid stays 1; on release, next value is 12.
- Branch request, br_base=20, br_ofs=-3:
  - target 12;
  - next cycle pc_valid=0 (BUBBLE);
  - following cycle pc_out=12, pc_valid=1.
- Simultaneous exc_valid, jmp_valid (target 100) and br_taken -> pc_out=VECTOR_PC (384), jump and branch are ignored.
- jmp_target=102 -> pc_out=100 and misalign pulses for 1 cycle. Separately, PC=1020 with increment -> pc_out=0.
- Halt/resume and mid-operation reset:
  - halt at pc_out=40 -> pc_valid=0 and PC held;
  - resume -> pc_out=40 with pc_valid=1;
  - rst_n low mid-RUN asynchronously forces pc_out=0 and pc_valid=0.
